// File: rtl/cpu7_ifu_fdpq.sv
// Fetch FSM plus circular instruction buffer: one fetch request in flight, up to FETCH_W instructions per response.
// Enqueued entries reach the decode head one cycle later; decode back-pressure only withholds fetch credits.
module cpu7_ifu_fdpq #(
  parameter int FETCH_W         = 4,
  parameter int IBUF_DEPTH      = 8,
  parameter int LSOC1K_PRU_HINT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                pc_init,
  output logic                       inst_req,
  output logic [31:0]                inst_addr,
  input  logic                       inst_addr_ok,
  input  logic                       inst_valid,
  input  logic [1:0]                 inst_count,
  input  logic [32*FETCH_W-1:0]      inst_rdata,
  input  logic                       inst_ex,
  input  logic [5:0]                 inst_exccode,
  output logic                       inst_cancel,
  input  logic                       br_cancel,
  input  logic [31:0]                br_target,
  output logic                       o_port0_valid,
  input  logic                       o_port0_ready,
  output logic [31:0]                o_port0_inst,
  output logic [31:0]                o_port0_pc,
  output logic                       o_port0_ex,
  output logic [5:0]                 o_port0_exccode,
  output logic [LSOC1K_PRU_HINT-1:0] o_port0_hint,
  output logic                       o_port0_taken,
  output logic [29:0]                o_port0_target
);

  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_REQ,
    S_WAIT,
    S_HALT,
    S_DROP
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     fpc, fpc_nxt;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_nxt, free_cnt;
  logic            rsp_take, deq;
  logic [2:0]      enq_n;

  logic [31:0]     mem_inst [IBUF_DEPTH];
  logic [31:0]     mem_pc   [IBUF_DEPTH];
  logic            mem_ex   [IBUF_DEPTH];
  logic [5:0]      mem_code [IBUF_DEPTH];

  logic [AW-1:0]   wr_idx  [FETCH_W];
  logic [31:0]     wr_inst [FETCH_W];
  logic [31:0]     wr_pc   [FETCH_W];

  // Credit check: a request is only issued when a full-width response is guaranteed to fit.
  assign free_cnt = CW'(IBUF_DEPTH) - count;
  assign inst_req = (state == S_REQ) && (free_cnt >= CW'(FETCH_W));
  assign inst_addr   = fpc;
  assign inst_cancel = br_cancel;

  assign rsp_take = (state == S_WAIT) && inst_valid && !br_cancel;
  assign deq      = o_port0_valid && o_port0_ready && !br_cancel;

  always_comb begin
    enq_n = 3'd0;
    if (rsp_take) begin
      enq_n = inst_ex ? 3'd1 : ({1'b0, inst_count} + 3'd1);
    end
  end

  always_comb begin
    count_nxt = count + CW'(enq_n) - {{(CW-1){1'b0}}, deq};
    if (br_cancel) begin
      count_nxt = '0;
    end
  end

  always_comb begin
    fpc_nxt = fpc;
    if (br_cancel) begin
      fpc_nxt = br_target;
    end else if (state == S_INIT) begin
      fpc_nxt = pc_init;
    end else if (rsp_take && !inst_ex) begin
      fpc_nxt = fpc + {27'd0, enq_n, 2'b00};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: state_nxt = S_REQ;
      S_REQ:  if (inst_req && inst_addr_ok) state_nxt = S_WAIT;
      S_WAIT: if (inst_valid) state_nxt = inst_ex ? S_HALT : S_REQ;
      S_HALT: state_nxt = S_HALT;
      S_DROP: if (inst_valid) state_nxt = S_REQ;
      default: state_nxt = S_INIT;
    endcase
    // A redirect overrides everything; an accepted-but-unanswered request must have its response swallowed.
    if (br_cancel) begin
      if ((state == S_WAIT && !inst_valid) || (state == S_REQ && inst_addr_ok)) begin
        state_nxt = S_DROP;
      end else begin
        state_nxt = S_REQ;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      wr_idx[i]  = wr_ptr + AW'(i);
      wr_pc[i]   = fpc + 32'(4 * i);
      wr_inst[i] = inst_ex ? 32'd0 : inst_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_INIT;
      fpc    <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nxt;
      fpc   <= fpc_nxt;
      count <= count_nxt;
      if (br_cancel) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + AW'(deq);
        wr_ptr <= wr_ptr + AW'(enq_n);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rsp_take) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i < int'(enq_n)) begin
          mem_inst[wr_idx[i]] <= wr_inst[i];
          mem_pc[wr_idx[i]]   <= wr_pc[i];
          mem_ex[wr_idx[i]]   <= inst_ex;
          mem_code[wr_idx[i]] <= inst_ex ? inst_exccode : 6'd0;
        end
      end
    end
  end

  // Head fields are forced to zero when empty so stale storage never leaks out.
  assign o_port0_valid   = (count != '0);
  assign o_port0_inst    = o_port0_valid ? mem_inst[rd_ptr] : 32'd0;
  assign o_port0_pc      = o_port0_valid ? mem_pc[rd_ptr]   : 32'd0;
  assign o_port0_ex      = o_port0_valid ? mem_ex[rd_ptr]   : 1'b0;
  assign o_port0_exccode = o_port0_valid ? mem_code[rd_ptr] : 6'd0;
  assign o_port0_hint    = '0;
  assign o_port0_taken   = 1'b0;
  assign o_port0_target  = '0;

endmodule
